// File: rtl/layer7_wrd_pkg.sv
// Shared types, constants and helpers for the layer-7 weight read sequencer.
package layer7_wrd_pkg;

  localparam int WORDS_PER_BANK = 25;
  localparam int LANES          = 8;
  localparam int LANE_W         = 16;
  localparam int WORD_W         = LANES * LANE_W;
  localparam int INDEX_W        = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // One captured word pair; 6 + 128 + 128 = 262 bits.
  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [WORD_W-1:0]  w2;
    logic [WORD_W-1:0]  w1;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  function automatic logic [LANE_W-1:0] lane_fold(input logic [WORD_W-1:0] w);
    logic [LANE_W-1:0] acc;
    acc = '0;
    for (int l = 0; l < LANES; l++) begin
      acc = acc ^ w[l*LANE_W +: LANE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/layer7_wrd_skid_fifo.sv
// Two-entry FIFO between SRAM capture and the PE handshake.
// Flush wins over a simultaneous push; head is presented combinationally.
module layer7_wrd_skid_fifo
  import layer7_wrd_pkg::*;
#(
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  localparam int DEPTH = 2;

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] cnt_reg;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (cnt_reg != 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      cnt_reg <= cnt_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_data  = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
  assign head_valid = (cnt_reg != 2'd0);
  assign count      = cnt_reg;

  // The issue throttle upstream must keep a push from landing on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && (cnt_reg == 2'd2)));

endmodule

// File: rtl/layer7_weight_read_ctrl.sv
// Read sequencer for the layer-7 weight SRAM: walks both banks in lockstep, absorbs the
// 1-cycle read latency and streams word pairs out. Define LAYER7_WRD_CKSUM_EN for cksum.
module layer7_weight_read_ctrl #(
  parameter int WORDS_PER_BANK = layer7_wrd_pkg::WORDS_PER_BANK,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = layer7_wrd_pkg::WORD_W,
  parameter int PASS_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PASS_W-1:0] num_passes,
  input  logic              abort,
  input  logic              wr_active,
  output logic              read_weight_signal,
  output logic [ADDR_W-1:0] read_weight_addr1,
  output logic [ADDR_W-1:0] read_weight_addr2,
  input  logic [DATA_W-1:0] read_weight_data1,
  input  logic [DATA_W-1:0] read_weight_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_weight1,
  output logic [DATA_W-1:0] out_weight2,
  output logic [5:0]        out_index,
  output logic              busy,
  output logic              done,
  output logic [15:0]       cksum
);

  import layer7_wrd_pkg::*;

  localparam int                IDX_W    = INDEX_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_BANK - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  inflight_idx_reg;
  logic [PASS_W-1:0] pass_reg;
  logic [PASS_W-1:0] passes_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] addr_hold_reg;

  logic              pop;
  logic              issue;
  logic              last_issue;
  logic              start_accept;
  logic              drain_empty;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occupancy;
  logic              head_valid;
  fifo_entry_t       push_entry;
  fifo_entry_t       head_entry;

  assign pop          = head_valid && out_ready;
  // Slots already committed: buffered + captured next edge, less what leaves this cycle.
  assign occupancy    = {1'b0, fifo_cnt} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue        = (state_reg == RUN) && !wr_active && !abort && (occupancy < 3'd2);
  assign last_issue   = issue && (idx_reg == LAST_IDX) &&
                        (pass_reg == passes_reg - PASS_W'(1));
  assign start_accept = (state_reg == IDLE) && start && !wr_active && !abort;
  // Empty after this edge: nothing in flight and the last buffered pair (if any) leaving now.
  assign drain_empty  = !inflight_reg &&
                        ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

  always_comb begin
    state_next         = state_reg;
    busy               = (state_reg != IDLE);
    done               = (state_reg == DONE);
    read_weight_signal = (state_reg == RUN) || (state_reg == DRAIN);
    read_weight_addr1  = '0;
    case (state_reg)
      IDLE:    if (start_accept) state_next = RUN;
      RUN:     if (last_issue)   state_next = DRAIN;
      DRAIN:   if (drain_empty)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
    if (read_weight_signal) begin
      read_weight_addr1 = issue ? ADDR_W'(idx_reg) : addr_hold_reg;
    end
    read_weight_addr2 = read_weight_addr1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      inflight_idx_reg <= '0;
      pass_reg         <= '0;
      passes_reg       <= '0;
      inflight_reg     <= 1'b0;
      addr_hold_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (issue) begin
        inflight_idx_reg <= idx_reg;
        addr_hold_reg    <= ADDR_W'(idx_reg);
      end else if (state_next == IDLE) begin
        addr_hold_reg <= '0;
      end
      if (start_accept) begin
        idx_reg    <= '0;
        pass_reg   <= '0;
        passes_reg <= (num_passes == '0) ? PASS_W'(1) : num_passes;
      end else if (issue) begin
        if (idx_reg == LAST_IDX) begin
          idx_reg  <= '0;
          pass_reg <= pass_reg + PASS_W'(1);
        end else begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  assign push_entry = '{index: inflight_idx_reg, w2: read_weight_data2, w1: read_weight_data1};

  layer7_wrd_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_skid_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_reg),
    .pop        (pop),
    .flush      (abort),
    .push_data  (push_entry),
    .head_data  (head_entry),
    .head_valid (head_valid),
    .count      (fifo_cnt)
  );

  assign out_valid   = head_valid;
  assign out_weight1 = head_valid ? head_entry.w1 : '0;
  assign out_weight2 = head_valid ? head_entry.w2 : '0;
  assign out_index   = head_valid ? head_entry.index : '0;

`ifdef LAYER7_WRD_CKSUM_EN
  logic [LANE_W-1:0] cksum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cksum_reg <= '0;
    end else if (start_accept) begin
      cksum_reg <= '0;
    end else if (pop) begin
      cksum_reg <= cksum_reg ^ lane_fold(head_entry.w1) ^ lane_fold(head_entry.w2);
    end
  end

  assign cksum = cksum_reg;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_layer7_weight_read_ctrl.sv
// Randomized self-checking bench for layer7_weight_read_ctrl against a sequence/queue model.
module tb_layer7_weight_read_ctrl;

  localparam int WPB = 25;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   num_passes;
  logic         abort;
  logic         wr_active;
  logic         read_weight_signal;
  logic [15:0]  read_weight_addr1;
  logic [15:0]  read_weight_addr2;
  logic [127:0] read_weight_data1 = '0;
  logic [127:0] read_weight_data2 = '0;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_weight1;
  logic [127:0] out_weight2;
  logic [5:0]   out_index;
  logic         busy;
  logic         done;
  logic [15:0]  cksum;

  always #5 clk = ~clk;

  layer7_weight_read_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .num_passes         (num_passes),
    .abort              (abort),
    .wr_active          (wr_active),
    .read_weight_signal (read_weight_signal),
    .read_weight_addr1  (read_weight_addr1),
    .read_weight_addr2  (read_weight_addr2),
    .read_weight_data1  (read_weight_data1),
    .read_weight_data2  (read_weight_data2),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_weight1        (out_weight1),
    .out_weight2        (out_weight2),
    .out_index          (out_index),
    .busy               (busy),
    .done               (done),
    .cksum              (cksum)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          pat = 0;
  logic [15:0] rnd_lane [50][8];
  logic [261:0] exp_q [$];
  logic [15:0] ck_model;
  logic [261:0] pair;

  assign pair = {out_index, out_weight2, out_weight1};

  task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents: 0 = all lanes k, 1 = lane#+8*k, otherwise a random table.
  function automatic logic [127:0] word_of(input int k);
    logic [127:0] w;
    w = '0;
    if (k < 0 || k > 49) return w;
    for (int l = 0; l < 8; l++) begin
      case (pat)
        0:       w[16*l +: 16] = 16'(k);
        1:       w[16*l +: 16] = 16'(l + 8*k);
        default: w[16*l +: 16] = rnd_lane[k][l];
      endcase
    end
    return w;
  endfunction

  function automatic logic [15:0] fold_pair(input logic [261:0] e);
    logic [15:0] f;
    f = '0;
    for (int l = 0; l < 16; l++) f = f ^ e[16*l +: 16];
    return f;
  endfunction

  function automatic logic [319:0] out_all();
    return 320'({cksum, done, busy, out_index, out_weight2, out_weight1, out_valid,
                 read_weight_addr2, read_weight_addr1, read_weight_signal});
  endfunction

  // SRAM model: registered read, bank B sits 25 words above bank A.
  always @(posedge clk) begin
    if (read_weight_signal) begin
      read_weight_data1 <= word_of(int'(read_weight_addr1));
      read_weight_data2 <= word_of(int'(read_weight_addr2) + WPB);
    end
  end

  task automatic fill_random();
    for (int k = 0; k < 50; k++)
      for (int l = 0; l < 8; l++) rnd_lane[k][l] = 16'($urandom);
  endtask

  // rmode: 0 ready=1, 1 toggle plus 5-cycle stall at index 10, 2 random.
  // wr_at: -1 none, -2 random wr_active and stray starts, >=0 4-cycle write at that index.
  task automatic run_seq(input string name, input int passes, input int rmode, input int wr_at,
                         input int kill_at, input bit kill_rst, input int exp_done_cyc);
    int cyc, first_valid, done_cyc, delivered, total, wr_left, stall_left, tgl;
    bit stalled_prev, freeze_chk, resume_chk, wr_used, stall_used, done_seen, killed, late;
    logic [261:0] prev_pair, exp_pair;
    logic [15:0]  exp_ck;
    cyc = 0; first_valid = -1; done_cyc = -1; delivered = 0; wr_left = 0; stall_left = 0;
    tgl = 0; stalled_prev = 0; wr_used = 0; stall_used = 0; done_seen = 0; killed = 0;
    prev_pair = '0;
    exp_q.delete();
    total = WPB * ((passes == 0) ? 1 : passes);
    for (int p = 0; p < ((passes == 0) ? 1 : passes); p++)
      for (int k = 0; k < WPB; k++) exp_q.push_back({6'(k), word_of(k + WPB), word_of(k)});
    ck_model = '0;

    @(posedge clk); #1;
    abort = 0; wr_active = 0; out_ready = 1; start = 1; num_passes = 8'(passes);
    @(posedge clk); #1;
    start = 0;

    for (int guard = 0; guard < 3000 && !done_seen && !killed; guard++) begin
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          if (!stall_used && out_valid && out_index == 6'd10) begin
            stall_used = 1; stall_left = 5;
          end
          if (stall_left > 0) begin
            out_ready = 1'b0; stall_left--;
          end else begin
            out_ready = (tgl % 2 == 0); tgl++;
          end
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      freeze_chk = 0; resume_chk = 0;
      if (wr_at == -2) begin
        wr_active = ($urandom_range(0, 4) == 0);
        start     = ($urandom_range(0, 7) == 0);
      end else if (wr_left > 0) begin
        wr_active = 1; wr_left--; freeze_chk = 1;
      end else if (wr_active) begin
        wr_active = 0; resume_chk = 1;
      end

      @(negedge clk);
      if (cyc == 0)
        check_eq("first_cycle_issue", 320'({busy, read_weight_signal, read_weight_addr1}),
                 320'({1'b1, 1'b1, 16'd0}));
      check_eq("addr_pair", 320'(read_weight_addr2), 320'(read_weight_addr1));
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (stalled_prev)
        check_eq("hold_stable", 320'({out_valid, pair}), 320'({1'b1, prev_pair}));
      if (freeze_chk) check_eq("addr_frozen", 320'(read_weight_addr1), 320'(wr_at));
      if (resume_chk) check_eq("addr_resume", 320'(read_weight_addr1), 320'(wr_at + 1));
      if (wr_at >= 0 && !wr_used && read_weight_signal && read_weight_addr1 == 16'(wr_at)) begin
        wr_used = 1; wr_left = 4;
      end

      if (kill_at >= 0 && out_valid && out_index == 6'(kill_at)) begin
        if (kill_rst) rst = 1; else abort = 1;
        @(posedge clk); #1;
        rst = 0; abort = 0; start = 0; wr_active = 0;
        @(negedge clk);
        if (kill_rst) check_eq("rst_all_zero", out_all(), 320'(0));
        else check_eq("abort_idle", 320'({busy, out_valid, done, read_weight_signal}), 320'(0));
        killed = 1;
      end else begin
        if (out_valid && out_ready) begin
          exp_pair = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          check_eq("pair", 320'(pair), 320'(exp_pair));
          ck_model = ck_model ^ fold_pair(exp_pair);
          delivered++;
        end
        if (done) begin
          done_seen = 1; done_cyc = cyc;
        end
        stalled_prev = out_valid && !out_ready;
        prev_pair = pair;
        if (!done_seen) begin
          @(posedge clk); #1;
          cyc++;
        end
      end
    end

    if (killed) begin
      late = 0;
      repeat (3) begin
        @(posedge clk); #1;
        @(negedge clk);
        late = late | done | busy;
      end
      check_eq("quiet_after_kill", 320'(late), 320'(0));
    end else begin
`ifdef LAYER7_WRD_CKSUM_EN
      exp_ck = ck_model;
`else
      exp_ck = '0;
`endif
      check_eq("done_seen", 320'(done_seen), 320'(1));
      check_eq("pair_count", 320'(delivered), 320'(total));
      if (wr_at != -2) check_eq("first_valid_latency", 320'(first_valid), 320'(2));
      if (exp_done_cyc >= 0) check_eq("done_cycle", 320'(done_cyc), 320'(exp_done_cyc));
      check_eq("cksum_at_done", 320'(cksum), 320'(exp_ck));
      @(posedge clk); #1;
      start = 0; wr_active = 0;
      @(negedge clk);
      check_eq("idle_after_done",
               320'({done, busy, out_valid, read_weight_signal, read_weight_addr1, cksum}),
               320'({4'b0000, 16'd0, exp_ck}));
    end
    $display("run %s passes=%0d delivered=%0d done_cyc=%0d killed=%0d",
             name, passes, delivered, done_cyc, killed);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; wr_active = 0; out_ready = 0; num_passes = '0;
    fill_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", out_all(), 320'(0));
    rst = 0;

    pat = 0; run_seq("T1_single_pass", 1, 0, -1, -1, 0, 27);
    pat = 2; run_seq("T2_three_passes", 3, 0, -1, -1, 0, 77);
    pat = 2; run_seq("T3_ready_toggle", 1, 1, -1, -1, 0, -1);
    pat = 0; run_seq("T4_write_stall", 1, 0, 7, -1, 0, 31);
    pat = 2; run_seq("T5_abort", 2, 0, -1, 12, 0, -1);
    pat = 2; run_seq("T5_rst", 1, 0, -1, 5, 1, -1);
    pat = 0; run_seq("T5_restart", 1, 0, -1, -1, 0, 27);
    pat = 1; run_seq("T6_cksum", 2, 0, -1, -1, 0, 52);
    pat = 1; run_seq("zero_passes", 0, 0, -1, -1, 0, 27);
    for (int i = 0; i < 4; i++) begin
      pat = 2;
      fill_random();
      run_seq("random", int'($urandom_range(0, 3)), 2, -2, -1, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
